square_wave_meter: RTL and testbench



---
 rtl/square_wave_meter_if.sv | 24 ++
 rtl/square_wave_meter.sv | 171 +++++++++++++++++
 tb/tb_square_wave_meter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/square_wave_meter_if.sv
// Signal bundle between a square-wave source/controller and square_wave_meter.
// The master drives the enable and the measured wave; the meter (slave) returns results.
interface square_wave_meter_if #(
  parameter int unsigned UNIT_W = 4
);
  logic              i_en;
  logic              i_q;
  logic [UNIT_W-1:0] o_m;
  logic [UNIT_W-1:0] o_n;
  logic              o_valid;
  logic              o_ovf;
  logic              o_stuck;
  logic              o_busy;

  modport master (
    output i_en, i_q,
    input  o_m, o_n, o_valid, o_ovf, o_stuck, o_busy
  );

  modport slave (
    input  i_en, i_q,
    output o_m, o_n, o_valid, o_ovf, o_stuck, o_busy
  );
endinterface

// File: rtl/square_wave_meter.sv
// Measures high/low durations of a possibly asynchronous square wave in units of
// CLK_PER_UNIT clocks and reports each complete high+low pair with a one-cycle strobe.
module square_wave_meter #(
  parameter int unsigned CLK_PER_UNIT = 10,
  parameter int unsigned UNIT_W       = 4
) (
  input logic               i_clk,
  input logic               i_rst_n,
  square_wave_meter_if.slave io_bus
);
  localparam int unsigned SUB_W = (CLK_PER_UNIT > 1) ? $clog2(CLK_PER_UNIT) : 1;
  localparam int unsigned CMP_W = ((UNIT_W > SUB_W) ? UNIT_W : SUB_W) + 1;

  localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'(CLK_PER_UNIT - 1);
  localparam logic [SUB_W-1:0]  SUB_ONE  = SUB_W'(1);
  localparam logic [UNIT_W-1:0] UNIT_MAX = {UNIT_W{1'b1}};
  localparam logic [CMP_W-1:0]  HALF_C   = CMP_W'(CLK_PER_UNIT / 2);
  localparam logic [CMP_W-1:0]  UMAX_C   = CMP_W'(UNIT_MAX);

  typedef enum logic [1:0] {StIdle, StSyncWait, StMeasHigh, StMeasLow} state_t;

  state_t            r_state;
  logic              r_s1, r_s2, r_s3;
  logic [SUB_W-1:0]  r_sub;
  logic [UNIT_W-1:0] r_unit;
  logic              r_povf;
  logic [UNIT_W-1:0] r_pend_m;
  logic              r_pend_ovf;
  logic [UNIT_W-1:0] r_m, r_n;
  logic              r_valid, r_ovf, r_stuck, r_busy;

  logic              w_rise, w_fall;
  logic [SUB_W-1:0]  w_sub_nxt;
  logic [UNIT_W-1:0] w_unit_nxt;
  logic              w_sat;
  logic [CMP_W-1:0]  w_round;
  logic [UNIT_W-1:0] w_res;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= io_bus.i_q;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise = r_s2 & ~r_s3;
  assign w_fall = ~r_s2 & r_s3;

  // Once the unit count has saturated, sub is parked at 0 so the closing value stays at max.
  always_comb begin
    w_sub_nxt  = r_sub;
    w_unit_nxt = r_unit;
    w_sat      = 1'b0;
    if (r_povf) begin
      w_sub_nxt = '0;
      w_sat     = 1'b1;
    end else if (r_sub == SUB_LAST) begin
      w_sub_nxt = '0;
      if (r_unit == UNIT_MAX) begin
        w_sat = 1'b1;
      end else begin
        w_unit_nxt = r_unit + UNIT_W'(1);
      end
    end else begin
      w_sub_nxt = r_sub + SUB_W'(1);
    end
  end

  always_comb begin
    w_round = CMP_W'(r_unit);
    if (CMP_W'(r_sub) >= HALF_C) begin
      w_round = CMP_W'(r_unit) + CMP_W'(1);
    end
    w_res = (w_round > UMAX_C) ? UNIT_MAX : w_round[UNIT_W-1:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_sub      <= '0;
      r_unit     <= '0;
      r_povf     <= 1'b0;
      r_pend_m   <= '0;
      r_pend_ovf <= 1'b0;
      r_m        <= '0;
      r_n        <= '0;
      r_valid    <= 1'b0;
      r_ovf      <= 1'b0;
      r_stuck    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      // Disable has priority over everything, including a closing rise this cycle.
      if (!io_bus.i_en) begin
        r_state    <= StIdle;
        r_sub      <= '0;
        r_unit     <= '0;
        r_povf     <= 1'b0;
        r_pend_m   <= '0;
        r_pend_ovf <= 1'b0;
        r_stuck    <= 1'b0;
        r_busy     <= 1'b0;
      end else begin
        case (r_state)
          StIdle: r_state <= StSyncWait;
          StSyncWait: begin
            if (w_rise) begin
              r_state <= StMeasHigh;
              r_sub   <= SUB_ONE;
              r_unit  <= '0;
              r_povf  <= 1'b0;
              r_stuck <= 1'b0;
              r_busy  <= 1'b1;
            end
          end
          StMeasHigh: begin
            if (w_fall) begin
              r_state    <= StMeasLow;
              r_pend_m   <= w_res;
              r_pend_ovf <= r_povf;
              r_sub      <= SUB_ONE;
              r_unit     <= '0;
              r_povf     <= 1'b0;
              r_stuck    <= 1'b0;
            end else begin
              r_sub  <= w_sub_nxt;
              r_unit <= w_unit_nxt;
              if (w_sat) begin
                r_povf  <= 1'b1;
                r_stuck <= 1'b1;
              end
            end
          end
          StMeasLow: begin
            if (w_rise) begin
              r_state <= StMeasHigh;
              r_m     <= r_pend_m;
              r_n     <= w_res;
              r_ovf   <= r_pend_ovf | r_povf;
              r_valid <= 1'b1;
              r_sub   <= SUB_ONE;
              r_unit  <= '0;
              r_povf  <= 1'b0;
              r_stuck <= 1'b0;
            end else begin
              r_sub  <= w_sub_nxt;
              r_unit <= w_unit_nxt;
              if (w_sat) begin
                r_povf  <= 1'b1;
                r_stuck <= 1'b1;
              end
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign io_bus.o_m     = r_m;
  assign io_bus.o_n     = r_n;
  assign io_bus.o_valid = r_valid;
  assign io_bus.o_ovf   = r_ovf;
  assign io_bus.o_stuck = r_stuck;
  assign io_bus.o_busy  = r_busy;
endmodule

// File: tb/tb_square_wave_meter.sv
// Bench for square_wave_meter: directed and random waveforms compared every cycle
// against a run-length model of the synchronized wave.
module tb_square_wave_meter;
  localparam int CPU  = 10;
  localparam int W    = 4;
  localparam int UMAX = (1 << W) - 1;
  localparam int LIM  = CPU * (1 << W);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  square_wave_meter_if #(.UNIT_W(W)) bus_if ();

  square_wave_meter #(
    .CLK_PER_UNIT(CPU),
    .UNIT_W      (W)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_bus (bus_if.slave)
  );

  int checks = 0;
  int errors = 0;

  // Model state: 0 idle, 1 waiting for rise, 2 high phase, 3 low phase.
  int ms, mlen, mpend_m, mpend_o;
  int mm, mn, movf, mvalid, mstuck, mbusy;
  bit qh [4];

  int cyc;
  int stuck_cnt;
  int rep_m[$], rep_n[$], rep_o[$], rep_t[$];

  function automatic int res(input int len);
    int r;
    r = (len + CPU / 2) / CPU;
    return (r > UMAX) ? UMAX : r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ms = 0; mlen = 0; mpend_m = 0; mpend_o = 0;
    mm = 0; mn = 0; movf = 0; mvalid = 0; mstuck = 0; mbusy = 0;
    for (int i = 0; i < 4; i++) qh[i] = 1'b0;
  endtask

  task automatic model(input bit e, input bit x, input bit y);
    bit rise, fall;
    rise = x && !y;
    fall = !x && y;
    mvalid = 0;
    if (!e) begin
      ms = 0; mlen = 0; mpend_m = 0; mpend_o = 0;
    end else begin
      case (ms)
        0: ms = 1;
        1: if (rise) begin ms = 2; mlen = 1; end
        2: begin
          if (fall) begin
            mpend_m = res(mlen);
            mpend_o = (mlen >= LIM) ? 1 : 0;
            mlen = 1;
            ms = 3;
          end else mlen++;
        end
        default: begin
          if (rise) begin
            mm = mpend_m;
            mn = res(mlen);
            movf = (mpend_o != 0 || mlen >= LIM) ? 1 : 0;
            mvalid = 1;
            mlen = 1;
            ms = 2;
          end else mlen++;
        end
      endcase
    end
    mstuck = (ms >= 2 && mlen >= LIM) ? 1 : 0;
    mbusy  = (ms >= 2) ? 1 : 0;
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, "_valid"}, bus_if.o_valid, mvalid);
    chk({tag, "_m"},     bus_if.o_m,     mm);
    chk({tag, "_n"},     bus_if.o_n,     mn);
    chk({tag, "_ovf"},   bus_if.o_ovf,   movf);
    chk({tag, "_stuck"}, bus_if.o_stuck, mstuck);
    chk({tag, "_busy"},  bus_if.o_busy,  mbusy);
  endtask

  // Drive one clock worth of input, advance the model, compare 1 ns after the edge.
  task automatic step(input bit q, input bit e);
    bus_if.i_q  = q;
    bus_if.i_en = e;
    @(posedge clk);
    qh[3] = qh[2]; qh[2] = qh[1]; qh[1] = qh[0]; qh[0] = q;
    model(e, qh[2], qh[3]);
    #1;
    cyc++;
    chk_outs("cyc");
    if (bus_if.o_valid === 1'b1) begin
      rep_m.push_back(int'(bus_if.o_m));
      rep_n.push_back(int'(bus_if.o_n));
      rep_o.push_back(int'(bus_if.o_ovf));
      rep_t.push_back(cyc);
    end
    if (bus_if.o_stuck === 1'b1) stuck_cnt++;
  endtask

  task automatic pulse(input int hi, input int lo);
    for (int i = 0; i < hi; i++) step(1'b1, 1'b1);
    for (int i = 0; i < lo; i++) step(1'b0, 1'b1);
  endtask

  task automatic trail();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
  endtask

  task automatic clear_reps();
    rep_m.delete(); rep_n.delete(); rep_o.delete(); rep_t.delete();
    stuck_cnt = 0;
  endtask

  task automatic restart();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    clear_reps();
  endtask

  task automatic chk_rep(input string tag, input int idx, input int m, input int n,
                         input int o);
    if (idx < rep_m.size()) begin
      chk({tag, "_m"}, rep_m[idx], m);
      chk({tag, "_n"}, rep_n[idx], n);
      chk({tag, "_ovf"}, rep_o[idx], o);
    end
  endtask

  initial begin
    cyc = 0;
    rst_n = 1'b0;
    bus_if.i_en = 1'b0;
    bus_if.i_q  = 1'b0;
    model_reset();
    clear_reps();
    repeat (2) @(negedge clk);
    chk_outs("reset");
    rst_n = 1'b1;

    // 30/50 wave with enable from reset release.
    for (int k = 0; k < 4; k++) pulse(30, 50);
    trail();
    chk("t1_count", rep_m.size(), 4);
    for (int i = 0; i < 4; i++) chk_rep("t1", i, 3, 5, 0);
    for (int i = 1; i < rep_t.size(); i++) chk("t1_gap", rep_t[i] - rep_t[i-1], 80);

    // Round half up.
    restart();
    pulse(24, 25);
    pulse(14, 15);
    trail();
    chk("t2_count", rep_m.size(), 2);
    chk_rep("t2a", 0, 2, 3, 0);
    chk_rep("t2b", 1, 1, 2, 0);

    // Long high phase saturates; following pair is clean.
    restart();
    pulse(200, 20);
    pulse(30, 50);
    trail();
    chk("t3_count", rep_m.size(), 2);
    chk_rep("t3a", 0, 15, 2, 1);
    chk_rep("t3b", 1, 3, 5, 0);
    chk("t3_stuck_cycles", stuck_cnt, 200 - LIM + 1);

    // Enable while the wave is mid-high: partial pair ignored.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    clear_reps();
    for (int i = 0; i < 25; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1);
    pulse(35, 45);
    trail();
    chk("t4_count", rep_m.size(), 1);
    chk_rep("t4", 0, 4, 5, 0);

    // Disable in the middle of the low phase.
    restart();
    pulse(30, 50);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    chk("t5a_count", rep_m.size(), 1);
    chk("t5a_busy", bus_if.o_busy, 0);
    chk("t5a_hold_m", bus_if.o_m, 3);
    chk("t5a_hold_n", bus_if.o_n, 5);

    // Disable on the very cycle the closing rise is seen.
    restart();
    pulse(30, 50);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    chk("t5c_count", rep_m.size(), 0);

    // Asynchronous reset mid-phase, between clock edges.
    restart();
    pulse(30, 50);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
    chk("t5b_pre_m", bus_if.o_m, 3);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk_outs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // One-clock high glitch.
    restart();
    for (int k = 0; k < 6; k++) pulse(1, 9);
    trail();
    chk("t6_count", rep_m.size(), 6);
    for (int i = 0; i < 6; i++) chk_rep("t6", i, 0, 1, 0);
    for (int i = 1; i < rep_t.size(); i++) chk("t6_gap", rep_t[i] - rep_t[i-1], 10);

    // Random pairs with occasional long phases and sporadic disables.
    restart();
    for (int k = 0; k < 25; k++) begin
      int hi, lo;
      hi = ($urandom_range(0, 7) == 0) ? $urandom_range(150, 175) : $urandom_range(1, 40);
      lo = ($urandom_range(0, 7) == 0) ? $urandom_range(150, 175) : $urandom_range(1, 40);
      for (int i = 0; i < hi; i++) step(1'b1, $urandom_range(0, 149) != 0);
      for (int i = 0; i < lo; i++) step(1'b0, $urandom_range(0, 149) != 0);
    end
    trail();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
